// File: rtl/pwm_deadtime_ctrl.sv
// Multi-channel complementary PWM with a shared period counter, period-boundary
// shadowed duty/dead-time, and a per-channel dead-time FSM driving hi/lo gates.
module pwm_deadtime_ctrl #(
    parameter int R    = 8,
    parameter int N    = 2,
    parameter int DT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N*R-1:0]   duty,
    input  logic [DT_W-1:0]  dead_time,
    output logic [N-1:0]     pwm_hi,
    output logic [N-1:0]     pwm_lo,
    output logic             period_end,
    output logic [3*N-1:0]   fsm_state
);

    typedef enum logic [2:0] {
        OFF      = 3'd0,
        LO_ON    = 3'd1,
        DT_TO_HI = 3'd2,
        HI_ON    = 3'd3,
        DT_TO_LO = 3'd4
    } ch_state_t;

    localparam logic [R-1:0] CNT_MAX = '1;

    logic [R-1:0]    cnt;
    logic [DT_W-1:0] dt_act;
    logic            load_shadow;
    logic            dt_zero;

    // Shadows only move at a period boundary, or freely while stopped.
    assign load_shadow = !en || (cnt == CNT_MAX);
    assign dt_zero     = (dt_act == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            dt_act     <= '0;
            period_end <= 1'b0;
        end else begin
            cnt        <= en ? cnt + R'(1) : '0;
            period_end <= en && (cnt == CNT_MAX - R'(1));
            if (load_shadow) begin
                dt_act <= dead_time;
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_ch
        logic [R-1:0]    duty_act;
        ch_state_t       state_q;
        ch_state_t       state_d;
        logic [DT_W-1:0] timer_q;
        logic [DT_W-1:0] timer_d;
        logic            raw;
        logic            dt_done;
        logic            hi_q;
        logic            lo_q;

        assign raw     = (cnt < duty_act);
        // Timer holds the count of dead cycles already spent minus one.
        assign dt_done = ({1'b0, timer_q} + (DT_W+1)'(1)) >= {1'b0, dt_act};

        always_comb begin
            state_d = state_q;
            timer_d = '0;
            if (!en) begin
                state_d = OFF;
            end else begin
                case (state_q)
                    OFF:      state_d = dt_zero ? LO_ON : DT_TO_LO;
                    LO_ON:    if (raw)  state_d = dt_zero ? HI_ON : DT_TO_HI;
                    HI_ON:    if (!raw) state_d = dt_zero ? LO_ON : DT_TO_LO;
                    DT_TO_HI: begin
                        if (!raw)         state_d = LO_ON;
                        else if (dt_done) state_d = HI_ON;
                        else              timer_d = timer_q + DT_W'(1);
                    end
                    DT_TO_LO: begin
                        if (raw)          state_d = HI_ON;
                        else if (dt_done) state_d = LO_ON;
                        else              timer_d = timer_q + DT_W'(1);
                    end
                    default:  state_d = OFF;
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q  <= OFF;
                timer_q  <= '0;
                duty_act <= '0;
                hi_q     <= 1'b0;
                lo_q     <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                hi_q    <= (state_d == HI_ON);
                lo_q    <= (state_d == LO_ON);
                if (load_shadow) begin
                    duty_act <= duty[k*R +: R];
                end
            end
        end

        assign pwm_hi[k]           = hi_q;
        assign pwm_lo[k]           = lo_q;
        assign fsm_state[3*k +: 3] = state_q;
    end

endmodule

// File: tb/tb_pwm_deadtime_ctrl.sv
// Scoreboard bench for pwm_deadtime_ctrl: an output-level gate model predicts
// {period_end, pwm_hi, pwm_lo} each cycle; a negedge monitor compares.
module tb_pwm_deadtime_ctrl;

  localparam int R    = 8;
  localparam int N    = 2;
  localparam int DT_W = 4;
  localparam int MAXC = (1 << R) - 1;
  localparam int W    = 2 * N + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic [N*R-1:0]   duty = '0;
  logic [DT_W-1:0]  dead_time = '0;
  logic [N-1:0]     pwm_hi;
  logic [N-1:0]     pwm_lo;
  logic             period_end;
  logic [3*N-1:0]   fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];

  pwm_deadtime_ctrl #(.R(R), .N(N), .DT_W(DT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .duty       (duty),
    .dead_time  (dead_time),
    .pwm_hi     (pwm_hi),
    .pwm_lo     (pwm_lo),
    .period_end (period_end),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: gate-level view of each channel
  int m_cnt;
  int m_dt;
  int m_duty[N];
  bit m_hi[N];
  bit m_lo[N];
  bit m_run[N];
  int m_gap[N];
  bit m_tgt[N];

  task automatic model_clear();
    m_cnt = 0;
    m_dt  = 0;
    for (int k = 0; k < N; k++) begin
      m_duty[k] = 0; m_hi[k] = 0; m_lo[k] = 0;
      m_run[k] = 0; m_gap[k] = 0; m_tgt[k] = 0;
    end
  endtask

  task automatic put_side(input int k, input bit s);
    m_hi[k] = s;
    m_lo[k] = !s;
  endtask

  // Leave the current side; the new side turns on after m_dt dark cycles.
  task automatic head_to(input int k, input bit s);
    if (m_dt == 0) begin
      put_side(k, s);
    end else begin
      m_hi[k] = 0; m_lo[k] = 0; m_gap[k] = 0; m_tgt[k] = s;
    end
  endtask

  task automatic model_step();
    logic [W-1:0] e;
    bit raw;
    int new_cnt;
    for (int k = 0; k < N; k++) begin
      raw = (m_cnt < m_duty[k]);
      if (!en) begin
        m_hi[k] = 0; m_lo[k] = 0; m_run[k] = 0;
      end else if (!m_run[k]) begin
        m_run[k] = 1;
        head_to(k, 1'b0);
      end else if (m_hi[k]) begin
        if (!raw) head_to(k, 1'b0);
      end else if (m_lo[k]) begin
        if (raw) head_to(k, 1'b1);
      end else if (raw != m_tgt[k]) begin
        put_side(k, raw);
      end else if (m_gap[k] + 1 >= m_dt) begin
        put_side(k, m_tgt[k]);
      end else begin
        m_gap[k]++;
      end
    end
    if (!en || m_cnt == MAXC) begin
      m_dt = int'(dead_time);
      for (int k = 0; k < N; k++) m_duty[k] = int'(duty[k*R +: R]);
    end
    new_cnt = en ? (m_cnt + 1) % (MAXC + 1) : 0;
    m_cnt = new_cnt;
    e[W-1] = (new_cnt == MAXC);
    for (int k = 0; k < N; k++) begin
      e[N + k] = m_hi[k];
      e[k]     = m_lo[k];
    end
    exp_q.push_back(e);
  endtask

  // Async reset in this bench is always applied during the clock-low phase.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear();
      if (clk) exp_q.push_back('0);
    end else begin
      model_step();
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {period_end, pwm_hi, pwm_lo};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t got pe=%b hi=%b lo=%b expected pe=%b hi=%b lo=%b",
                 $time, a[W-1], a[2*N-1:N], a[N-1:0], e[W-1], e[2*N-1:N], e[N-1:0]);
      end
      n_cmp++;
      if ((pwm_hi & pwm_lo) != '0) begin
        n_bad++;
        $display("FAIL overlap t=%0t got hi=%b lo=%b expected no common bit", $time, pwm_hi, pwm_lo);
      end
    end
  end

  // driver tasks
  task automatic apply(input bit e, input int d0, input int d1, input int dt, input int cycles);
    en        = e;
    duty      = {R'(d1), R'(d0)};
    dead_time = DT_W'(dt);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic check_dark(input string name);
    n_cmp++;
    if ({period_end, pwm_hi, pwm_lo} !== '0) begin
      n_bad++;
      $display("FAIL %s got pe=%b hi=%b lo=%b expected all 0", name, period_end, pwm_hi, pwm_lo);
    end
  endtask

  function automatic int pick_duty();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return MAXC;
      2:       return $urandom_range(1, 6);
      default: return $urandom_range(0, MAXC);
    endcase
  endfunction

  initial begin
    #1;
    check_dark("reset_state");
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;

    // dead_time 0, exact complements
    apply(1'b0, 64, 128, 0, 3);
    apply(1'b1, 64, 128, 0, 600);
    // dead_time 3
    apply(1'b1, 64, 128, 3, 600);
    // mid-period duty change waits for the period boundary
    apply(1'b1, 64, 128, 3, 100);
    apply(1'b1, 192, 128, 3, 600);
    // pulse shorter than dead time
    apply(1'b1, 2, 100, 5, 600);
    // duty extremes
    apply(1'b1, 0, 255, 2, 600);
    // drop enable mid-period, then resume
    apply(1'b1, 90, 30, 4, 77);
    apply(1'b0, 90, 30, 4, 5);
    apply(1'b1, 90, 30, 4, 300);

    // asynchronous reset between edges
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_dark("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    apply(1'b1, 120, 40, 2, 600);

    // randomized segments
    for (int s = 0; s < 20; s++) begin
      apply($urandom_range(0, 7) != 0, pick_duty(), pick_duty(),
            $urandom_range(0, (1 << DT_W) - 1), $urandom_range(30, 450));
    end

    apply(1'b0, 0, 0, 0, 3);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d queued expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
